// File: rtl/ecc_pkg.sv
// Shared types and SEC/DED code tables for the scrub controller.
// The code is Hamming(21,16) plus an overall parity bit, stored as {parity, hamming[4:0], data}.
package ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HRD  = 3'd1,
    ST_HRSP = 3'd2,
    ST_HWR  = 3'd3,
    ST_SRD  = 3'd4,
    ST_SCHK = 3'd5,
    ST_SWB  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_CLEAN  = 2'b00;
  localparam logic [1:0] ERR_CORR   = 2'b01;
  localparam logic [1:0] ERR_UNCORR = 2'b10;

  localparam int ECC_DW = 16;
  localparam int ECC_HW = 5;
  localparam int ECC_CW = 6;

  // Data column i is the classic Hamming position of data bit i (non-powers of two 3..21).
  localparam logic [ECC_DW*ECC_HW-1:0] H_COLS = {
    5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd15, 5'd14, 5'd13,
    5'd12, 5'd11, 5'd10, 5'd9,  5'd7,  5'd6,  5'd5,  5'd3
  };

  function automatic logic [ECC_HW-1:0] h_col(input int idx);
    return H_COLS[idx*ECC_HW +: ECC_HW];
  endfunction

  // Data bits that feed Hamming check bit 'row'.
  function automatic logic [ECC_DW-1:0] h_row_mask(input int row);
    logic [ECC_DW-1:0] m;
    m = '0;
    for (int i = 0; i < ECC_DW; i++) begin
      m[i] = H_COLS[i*ECC_HW + row];
    end
    return m;
  endfunction

  // One-hot data flip mask for a syndrome; zero when it names a check bit or no column.
  function automatic logic [ECC_DW-1:0] syn_to_bit(input logic [ECC_HW-1:0] syn);
    logic [ECC_DW-1:0] m;
    m = '0;
    for (int i = 0; i < ECC_DW; i++) begin
      m[i] = (h_col(i) == syn);
    end
    return m;
  endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_codec.sv
// Combinational SEC/DED encoder and decoder sharing the package H-matrix.
// A single odd-parity result is treated as correctable; even parity with nonzero syndrome is a UE.
module secded_codec
  import ecc_pkg::*;
(
  input  logic [ECC_DW-1:0]        i_enc_data,
  output logic [ECC_CW-1:0]        o_enc_check,
  input  logic [ECC_DW+ECC_CW-1:0] i_dec_word,
  output logic [ECC_DW-1:0]        o_dec_data,
  output logic                     o_dec_ce,
  output logic                     o_dec_ue
);

  logic [ECC_HW-1:0] w_enc_ham;
  logic [ECC_HW-1:0] w_dec_ham;
  logic [ECC_HW-1:0] w_syn;
  logic [ECC_DW-1:0] w_dec_raw;
  logic [ECC_CW-1:0] w_dec_chk;
  logic              w_parity_err;

  assign w_dec_raw = i_dec_word[ECC_DW-1:0];
  assign w_dec_chk = i_dec_word[ECC_DW+ECC_CW-1:ECC_DW];

  generate
    for (genvar gi = 0; gi < ECC_HW; gi++) begin : g_row
      assign w_enc_ham[gi] = ^(i_enc_data & h_row_mask(gi));
      assign w_dec_ham[gi] = ^(w_dec_raw & h_row_mask(gi));
    end
  endgenerate

  assign o_enc_check = {^{i_enc_data, w_enc_ham}, w_enc_ham};

  assign w_syn        = w_dec_ham ^ w_dec_chk[ECC_HW-1:0];
  assign w_parity_err = ^i_dec_word;

  assign o_dec_ce   = w_parity_err;
  assign o_dec_ue   = !w_parity_err && (w_syn != '0);
  assign o_dec_data = w_parity_err ? (w_dec_raw ^ syn_to_bit(w_syn)) : w_dec_raw;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Host/scrubber arbiter for a single-port SEC/DED memory with 1-cycle read latency.
// Scrub sequences are atomic; the host wins any tie in IDLE.
module ecc_scrub_ctrl
  import ecc_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int CW       = 6,
  parameter int INTERVAL = 256,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scrub_en,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [DW-1:0]    host_rdata,
  output logic [1:0]       host_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW+CW-1:0] mem_wdata,
  input  logic [DW+CW-1:0] mem_rdata,
  output logic [CNT_W-1:0] ce_cnt,
  output logic [CNT_W-1:0] ue_cnt,
  output logic [AW-1:0]    ue_addr,
  output logic             pass_done
);

  localparam int            TW           = $clog2(INTERVAL);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(INTERVAL - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_corr;
  logic [AW-1:0]    r_scrub_addr;
  logic [TW-1:0]    r_timer;
  logic             r_scrub_en_d;
  logic [CNT_W-1:0] r_ce_cnt;
  logic [CNT_W-1:0] r_ue_cnt;
  logic [AW-1:0]    r_ue_addr;

  logic             w_en_rise;
  logic             w_scrub_due;
  logic             w_scrub_adv;
  logic             w_ce_inc;
  logic             w_ue_inc;
  logic [DW-1:0]    w_enc_data;
  logic [CW-1:0]    w_enc_check;
  logic [DW-1:0]    w_dec_data;
  logic             w_dec_ce;
  logic             w_dec_ue;

  logic [DW-1:0]    w_unused_enc_dec_data;
  logic             w_unused_enc_ce;
  logic             w_unused_enc_ue;
  logic [CW-1:0]    w_unused_dec_check;

  assign w_enc_data = (r_state == ST_SWB) ? r_corr : r_wdata;

  secded_codec u_enc (
    .i_enc_data  (w_enc_data),
    .o_enc_check (w_enc_check),
    .i_dec_word  ('0),
    .o_dec_data  (w_unused_enc_dec_data),
    .o_dec_ce    (w_unused_enc_ce),
    .o_dec_ue    (w_unused_enc_ue)
  );

  secded_codec u_dec (
    .i_enc_data  ('0),
    .o_enc_check (w_unused_dec_check),
    .i_dec_word  (mem_rdata),
    .o_dec_data  (w_dec_data),
    .o_dec_ce    (w_dec_ce),
    .o_dec_ue    (w_dec_ue)
  );

  // A fresh enable only reloads the timer; the first scrub waits a full interval.
  assign w_en_rise   = scrub_en && !r_scrub_en_d;
  assign w_scrub_due = scrub_en && !w_en_rise && (r_timer == '0);

  always_comb begin
    w_state_next = r_state;
    host_gnt     = 1'b0;
    host_rvalid  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    w_scrub_adv  = 1'b0;
    w_ce_inc     = 1'b0;
    w_ue_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (host_req) begin
          host_gnt     = !rst;
          w_state_next = host_we ? ST_HWR : ST_HRD;
        end else if (w_scrub_due) begin
          w_state_next = ST_SRD;
        end
      end
      ST_HRD: begin
        mem_req      = 1'b1;
        mem_addr     = r_addr;
        w_state_next = ST_HRSP;
      end
      ST_HRSP: begin
        host_rvalid  = 1'b1;
        w_ce_inc     = w_dec_ce;
        w_ue_inc     = w_dec_ue;
        w_state_next = ST_IDLE;
      end
      ST_HWR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = r_addr;
        w_state_next = ST_IDLE;
      end
      ST_SRD: begin
        mem_req      = 1'b1;
        mem_addr     = r_scrub_addr;
        w_state_next = ST_SCHK;
      end
      ST_SCHK: begin
        if (w_dec_ce) begin
          w_ce_inc     = 1'b1;
          w_state_next = ST_SWB;
        end else begin
          w_ue_inc     = w_dec_ue;
          w_scrub_adv  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_SWB: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = r_scrub_addr;
        w_scrub_adv  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign mem_wdata  = mem_we ? {w_enc_check, w_enc_data} : '0;
  assign host_rdata = host_rvalid ? w_dec_data : '0;
  assign host_err   = !host_rvalid ? ERR_CLEAN :
                      w_dec_ue     ? ERR_UNCORR :
                      w_dec_ce     ? ERR_CORR   : ERR_CLEAN;
  assign pass_done  = w_scrub_adv && (r_scrub_addr == '1);

  assign ce_cnt  = r_ce_cnt;
  assign ue_cnt  = r_ue_cnt;
  assign ue_addr = r_ue_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_corr       <= '0;
      r_scrub_addr <= '0;
      r_timer      <= '0;
      r_scrub_en_d <= 1'b0;
      r_ce_cnt     <= '0;
      r_ue_cnt     <= '0;
      r_ue_addr    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_scrub_en_d <= scrub_en;
      if (host_gnt) begin
        r_addr  <= host_addr;
        r_wdata <= host_wdata;
      end
      if (r_state == ST_SCHK) begin
        r_corr <= w_dec_data;
      end
      if (w_scrub_adv) begin
        r_scrub_addr <= r_scrub_addr + 1'b1;
      end
      if (w_scrub_adv || w_en_rise) begin
        r_timer <= TIMER_RELOAD;
      end else if (scrub_en && (r_timer != '0)) begin
        r_timer <= r_timer - 1'b1;
      end
      if (w_ce_inc && (r_ce_cnt != '1)) begin
        r_ce_cnt <= r_ce_cnt + 1'b1;
      end
      if (w_ue_inc) begin
        r_ue_addr <= (r_state == ST_HRSP) ? r_addr : r_scrub_addr;
        if (r_ue_cnt != '1) begin
          r_ue_cnt <= r_ue_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a behavioural 1-cycle-latency memory.
module tb_ecc_scrub_ctrl;
  localparam int AW       = 5;
  localparam int DW       = 16;
  localparam int CW       = 6;
  localparam int INTERVAL = 4;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             scrub_en;
  logic             host_req;
  logic             host_we;
  logic [AW-1:0]    host_addr;
  logic [DW-1:0]    host_wdata;
  logic             host_gnt;
  logic             host_rvalid;
  logic [DW-1:0]    host_rdata;
  logic [1:0]       host_err;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW+CW-1:0] mem_wdata;
  logic [DW+CW-1:0] mem_rdata;
  logic [CNT_W-1:0] ce_cnt;
  logic [CNT_W-1:0] ue_cnt;
  logic [AW-1:0]    ue_addr;
  logic             pass_done;

  logic [DW+CW-1:0] mem_model [2**AW];
  logic             mem_init;
  logic             pl_en;
  logic [AW-1:0]    pl_addr;
  logic [DW+CW-1:0] pl_word;

  int total;
  int bad;
  int pass_cnt;
  int rd_log[$];
  int wr_log[$];

  ecc_scrub_ctrl #(
    .AW(AW), .DW(DW), .CW(CW), .INTERVAL(INTERVAL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt), .ue_addr(ue_addr),
    .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2**AW; i++) mem_model[i] <= '0;
    end else if (pl_en) begin
      mem_model[pl_addr] <= pl_word;
    end else if (mem_req && mem_we) begin
      mem_model[mem_addr] <= mem_wdata;
    end
    if (mem_req && !mem_we) mem_rdata <= mem_model[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_req && !mem_we) rd_log.push_back(int'(mem_addr));
    if (mem_req && mem_we) wr_log.push_back(int'(mem_addr));
    if (pass_done) pass_cnt++;
  end

  // Reference encoder: data bits occupy the non-power-of-two Hamming positions 3..21.
  function automatic logic [21:0] tb_encode(input logic [15:0] d);
    logic [4:0] ham;
    int k;
    ham = '0;
    k = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[k]) ham ^= 5'(pos);
        k++;
      end
    end
    return {^{d, ham}, ham, d};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [21:0] w);
    pl_addr = a;
    pl_word = w;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
    $display("txn: preload addr=%0d word=0x%06h", a, w);
  endtask

  // Raise a request, wait (bounded) for the grant, return one cycle after it.
  task automatic req_host(input string tag, input logic we, input logic [AW-1:0] a,
                          input logic [15:0] d, input int max_wait);
    int waited;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    waited     = 0;
    #1;
    while (!host_gnt && waited < max_wait) begin
      step();
      #1;
      waited++;
    end
    check_val({tag, "_gnt"}, 32'(host_gnt), 32'd1);
    $display("txn: host %s addr=%0d wdata=0x%04h waited=%0d", we ? "wr" : "rd", a, d, waited);
    step();
    host_req = 1'b0;
    host_we  = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [AW-1:0] a,
                           input logic [15:0] exp_d, input logic [1:0] exp_e);
    req_host(tag, 1'b0, a, 16'h0, 20);
    check_val({tag, "_hrd_rvalid"}, 32'(host_rvalid), 32'd0);
    check_val({tag, "_hrd_memreq"}, 32'({mem_req, mem_we}), 32'b10);
    step();
    check_val({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
    check_val({tag, "_rdata"}, 32'(host_rdata), 32'(exp_d));
    check_val({tag, "_err"}, 32'(host_err), 32'(exp_e));
    $display("txn: host rd addr=%0d rdata=0x%04h err=%0b", a, host_rdata, host_err);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [21:0] bad10;
    logic [21:0] bad20;
    logic [21:0] bad1;
    total = 0; bad = 0; pass_cnt = 0;
    rst = 1'b1; scrub_en = 1'b0; host_req = 1'b1; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    mem_init = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_word = '0;
    repeat (2) @(posedge clk);
    #3;
    check_val("rst_gnt", 32'(host_gnt), 32'd0);
    check_val("rst_rvalid", 32'(host_rvalid), 32'd0);
    check_val("rst_mem", 32'({mem_req, mem_we, mem_addr}), 32'd0);
    check_val("rst_cnts", 32'({ce_cnt, ue_cnt, ue_addr}), 32'd0);
    check_val("rst_pass", 32'(pass_done), 32'd0);
    mem_init = 1'b0; host_req = 1'b0; rst = 1'b0;
    step();

    // Host write then read back
    req_host("wr3", 1'b1, 5'd3, 16'hA5A5, 20);
    check_val("wr3_memctl", 32'({mem_req, mem_we}), 32'b11);
    check_val("wr3_addr", 32'(mem_addr), 32'd3);
    check_val("wr3_wdata", 32'(mem_wdata), 32'h0027A5A5);
    step();
    check_val("wr3_idle_memreq", 32'(mem_req), 32'd0);
    host_read("rd3", 5'd3, 16'hA5A5, 2'b00);

    // Host read of a single-bit data error
    preload(5'd5, tb_encode(16'h1234) ^ 22'h80);
    wr_log.delete();
    host_read("rd5", 5'd5, 16'h1234, 2'b01);
    check_val("rd5_ce_cnt", 32'(ce_cnt), 32'd1);
    check_val("rd5_no_write", 32'(wr_log.size()), 32'd0);

    // Full scrub pass from address 0 with a CE at 10 and a UE at 20
    bad10 = tb_encode(16'hBEEF) ^ 22'h8;
    bad20 = tb_encode(16'h0F0F) ^ 22'h202;
    preload(5'd10, bad10);
    preload(5'd20, bad20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst2_ce_cnt", 32'(ce_cnt), 32'd0);
    rd_log.delete(); wr_log.delete(); pass_cnt = 0;
    scrub_en = 1'b1;
    $display("txn: scrub enabled for full pass");
    n = 0;
    while (pass_cnt == 0 && n < 2000) begin
      step();
      n++;
    end
    scrub_en = 1'b0;
    repeat (10) step();
    check_val("pass_cnt", 32'(pass_cnt), 32'd1);
    check_val("pass_reads", 32'(rd_log.size()), 32'd32);
    for (int i = 0; i < 32 && i < rd_log.size(); i++) begin
      check_val($sformatf("pass_order_%0d", i), 32'(rd_log[i]), 32'(i));
    end
    check_val("pass_writes", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      check_val("pass_wb0", 32'(wr_log[0]), 32'd5);
      check_val("pass_wb1", 32'(wr_log[1]), 32'd10);
    end
    check_val("pass_ce_cnt", 32'(ce_cnt), 32'd2);
    check_val("pass_ue_cnt", 32'(ue_cnt), 32'd1);
    check_val("pass_ue_addr", 32'(ue_addr), 32'd20);
    check_val("pass_mem10", 32'(mem_model[10]), 32'(tb_encode(16'hBEEF)));
    check_val("pass_mem5", 32'(mem_model[5]), 32'(tb_encode(16'h1234)));
    check_val("pass_mem20", 32'(mem_model[20]), 32'(bad20));
    host_read("rd10", 5'd10, 16'hBEEF, 2'b00);
    host_read("rd20", 5'd20, 16'h0F0F ^ 16'h0202, 2'b10);
    check_val("rd20_ue_cnt", 32'(ue_cnt), 32'd2);

    // Host vs scrub arbitration, then reset during a write-back
    rst = 1'b1;
    step();
    rst = 1'b0;
    preload(5'd0, tb_encode(16'h5555) ^ 22'h4);
    bad1 = tb_encode(16'h3333) ^ 22'h1000;
    preload(5'd1, bad1);
    scrub_en = 1'b1;
    repeat (4) step();
    req_host("tie", 1'b1, 5'd7, 16'h00FF, 0);
    check_val("tie_hwr_addr", 32'({mem_req, mem_we, mem_addr}), 32'({2'b11, 5'd7}));
    step();
    check_val("tie_idle", 32'(mem_req), 32'd0);
    step();
    check_val("tie_srd", 32'({mem_req, mem_we, mem_addr}), 32'({2'b10, 5'd0}));
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'd7;
    #1;
    check_val("schk_no_gnt", 32'(host_gnt), 32'd0);
    step();
    check_val("swb_no_gnt", 32'(host_gnt), 32'd0);
    check_val("swb_ctl", 32'({mem_req, mem_we, mem_addr}), 32'({2'b11, 5'd0}));
    check_val("swb_wdata", 32'(mem_wdata), 32'(tb_encode(16'h5555)));
    check_val("swb_ce_cnt", 32'(ce_cnt), 32'd1);
    step();
    check_val("post_swb_gnt", 32'(host_gnt), 32'd1);
    $display("txn: pending host rd addr=7 granted after write-back");
    step();
    host_req = 1'b0;
    step();
    check_val("rd7_rvalid", 32'(host_rvalid), 32'd1);
    check_val("rd7_rdata", 32'(host_rdata), 32'h00FF);
    n = 0;
    while (!(mem_req && mem_we && mem_addr == 5'd1) && n < 100) begin
      step();
      n++;
    end
    check_val("swb1_reached", 32'({mem_req, mem_we, mem_addr}), 32'({2'b11, 5'd1}));
    rst = 1'b1;
    #1;
    check_val("rst_swb_mem", 32'(|{mem_req, mem_we, mem_addr, mem_wdata}), 32'd0);
    check_val("rst_swb_host", 32'(|{host_gnt, host_rvalid, host_rdata, host_err}), 32'd0);
    check_val("rst_swb_cnts", 32'(|{ce_cnt, ue_cnt, ue_addr, pass_done}), 32'd0);
    $display("txn: reset asserted during write-back");
    step();
    rst = 1'b0;
    scrub_en = 1'b0;
    step();
    check_val("rst_swb_mem1", 32'(mem_model[1]), 32'(bad1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
